// File: rtl/ppu_sprite_eval.sv
// Per-scanline sprite evaluation: clears secondary OAM, copies up to 8 in-range sprites,
// and produces the sprite-overflow and sprite-0-present flags for the fetch/render path.
module ppu_sprite_eval #(
   parameter int NUM_SPR   = 64,
   parameter int SEC_SLOTS = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [8:0] x_i,
   input  logic [8:0] y_i,
   input  logic       rendering_en_i,
   input  logic       spr_h16_i,
   output logic [7:0] oam_addr_o,
   input  logic [7:0] oam_data_i,
   output logic [4:0] sec_oam_addr_o,
   output logic [7:0] sec_oam_wdata_o,
   output logic       sec_oam_we_o,
   output logic       spr_overflow_o,
   output logic       spr0_in_line_o,
   output logic [3:0] spr_count_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK_Y,
      ST_COPY,
      ST_OVF_SCAN,
      ST_DONE
   } state_t;

   localparam logic [5:0] N_LAST    = 6'(NUM_SPR - 1);
   localparam logic [3:0] SLOTS_MAX = 4'(SEC_SLOTS);

   state_t     state_q, state_d;
   logic [5:0] n_q, n_d;
   logic [1:0] m_q, m_d;
   logic [3:0] count_q, count_d;
   logic       spr0_q, spr0_d;
   logic       ovf_q, ovf_d;
   logic [3:0] cnt_lat_q, cnt_lat_d;
   logic       spr0_lat_q, spr0_lat_d;

   logic       active;
   logic [8:0] diff;
   logic       in_range;
   logic       n_last;
   logic       clear_wr;
   logic       we_c;
   logic [4:0] addr_c;
   logic [7:0] wdata_c;

   assign active   = (y_i <= 9'd239) && rendering_en_i;
   // Negative differences wrap to large unsigned values and fall out of range.
   assign diff     = y_i - {1'b0, oam_data_i};
   assign in_range = diff < (spr_h16_i ? 9'd16 : 9'd8);
   assign n_last   = (n_q == N_LAST);
   assign clear_wr = active && (x_i >= 9'd1) && (x_i <= 9'd64) && !x_i[0];

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      m_d        = m_q;
      count_d    = count_q;
      spr0_d     = spr0_q;
      ovf_d      = ovf_q;
      cnt_lat_d  = cnt_lat_q;
      spr0_lat_d = spr0_lat_q;
      we_c       = 1'b0;
      addr_c     = 5'd0;
      wdata_c    = 8'h00;

      if (clear_wr) begin
         we_c    = 1'b1;
         addr_c  = 5'(x_i[6:1] - 6'd1);
         wdata_c = 8'hFF;
      end

      case (state_q)
         ST_CHECK_Y: begin
            if (in_range && (count_q < SLOTS_MAX)) begin
               we_c    = 1'b1;
               addr_c  = {count_q[2:0], 2'b00};
               wdata_c = oam_data_i;
               m_d     = 2'd1;
               state_d = ST_COPY;
               if (n_q == 6'd0) begin
                  spr0_d = 1'b1;
               end
            end else begin
               n_d = n_q + 6'd1;
               if (n_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_COPY: begin
            we_c    = 1'b1;
            addr_c  = {count_q[2:0], m_q};
            wdata_c = oam_data_i;
            m_d     = m_q + 2'd1;
            if (m_q == 2'd3) begin
               count_d = count_q + 4'd1;
               n_d     = n_q + 6'd1;
               m_d     = 2'd0;
               if (n_last) begin
                  state_d = ST_DONE;
               end else if ((count_q + 4'd1) == SLOTS_MAX) begin
                  state_d = ST_OVF_SCAN;
               end else begin
                  state_d = ST_CHECK_Y;
               end
            end
         end
         ST_OVF_SCAN: begin
            if (in_range) begin
               ovf_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               // Hardware quirk: the byte index advances together with the entry index.
               n_d = n_q + 6'd1;
               m_d = m_q + 2'd1;
               if (n_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
         end
      endcase

      if (active && (x_i == 9'd64)) begin
         state_d = ST_CHECK_Y;
         n_d     = 6'd0;
         m_d     = 2'd0;
         count_d = 4'd0;
         spr0_d  = 1'b0;
      end

      if (!active || (x_i == 9'd257)) begin
         state_d = ST_IDLE;
      end

      if (x_i == 9'd256) begin
         cnt_lat_d  = active ? count_q : 4'd0;
         spr0_lat_d = active ? spr0_q : 1'b0;
      end

      if ((y_i == 9'd261) && (x_i == 9'd1)) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         n_q        <= 6'd0;
         m_q        <= 2'd0;
         count_q    <= 4'd0;
         spr0_q     <= 1'b0;
         ovf_q      <= 1'b0;
         cnt_lat_q  <= 4'd0;
         spr0_lat_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         m_q        <= m_d;
         count_q    <= count_d;
         spr0_q     <= spr0_d;
         ovf_q      <= ovf_d;
         cnt_lat_q  <= cnt_lat_d;
         spr0_lat_q <= spr0_lat_d;
      end
   end

   // Write strobe is gated combinationally so a disable or reset stops writes in the same cycle.
   assign sec_oam_we_o    = we_c && active && !rst_i;
   assign sec_oam_addr_o  = sec_oam_we_o ? addr_c : 5'd0;
   assign sec_oam_wdata_o = sec_oam_we_o ? wdata_c : 8'h00;
   assign oam_addr_o      = ((state_q == ST_IDLE) || (state_q == ST_DONE)) ? 8'h00 : {n_q, m_q};
   assign spr_overflow_o  = ovf_q;
   assign spr0_in_line_o  = spr0_lat_q;
   assign spr_count_o     = cnt_lat_q;

endmodule
